// File: rtl/core_wb_data_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : core_wb_data_bridge
//  Description : Converts the crypto core's req/gnt/rvalid data port into a
//                Wishbone classic master. One transaction can be outstanding
//                at a time. The bridge decodes an address window and applies
//                an ack timeout. Faults are returned to the core as err_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_wb_data_bridge #(
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hF000_0000,
   parameter logic [7:0]  TIMEOUT   = 8'd255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   // core data port
   input  logic        req_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        err_o,
   // Wishbone classic master
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q,    state_d;
   logic        cyc_q,      cyc_d;
   logic        stb_q,      stb_d;
   logic        we_q,       we_d;
   logic [3:0]  sel_q,      sel_d;
   logic [31:0] adr_q,      adr_d;
   logic [31:0] dat_q,      dat_d;
   logic        rvalid_q,   rvalid_d;
   logic [31:0] rdata_q,    rdata_d;
   logic        err_q,      err_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;

   logic        in_window;

   assign in_window = ((addr_i & ADDR_MASK) == ADDR_BASE);
   assign gnt_o     = req_i & (state_q == ST_IDLE);
   assign busy_o    = (state_q != ST_IDLE);

   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;

   // Next-state and next-output logic for the IDLE -> BUS -> RESP sequence
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      sel_d      = sel_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      rvalid_d   = 1'b0;
      rdata_d    = rdata_q;
      err_d      = err_q;
      wait_cnt_d = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (gnt_o) begin
               // attributes are captured on every grant; only the window
               // decision controls whether a bus cycle is actually started
               we_d  = we_i;
               sel_d = be_i;
               adr_d = {addr_i[31:2], 2'b00};
               dat_d = wdata_i;
               if (in_window) begin
                  state_d    = ST_BUS;
                  cyc_d      = 1'b1;
                  stb_d      = 1'b1;
                  wait_cnt_d = 8'd0;
               end else begin
                  state_d  = ST_RESP;
                  rvalid_d = 1'b1;
                  err_d    = 1'b1;
                  rdata_d  = 32'd0;
               end
            end
         end

         ST_BUS: begin
            // slave responses take priority over the timeout; err beats ack
            if (wbm_err_i || wbm_ack_i || (wait_cnt_q == TIMEOUT)) begin
               state_d  = ST_RESP;
               cyc_d    = 1'b0;
               stb_d    = 1'b0;
               rvalid_d = 1'b1;
               if (!wbm_err_i && wbm_ack_i) begin
                  err_d   = 1'b0;
                  rdata_d = we_q ? 32'd0 : wbm_dat_i;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; async reset drops the bus cycle at once
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         sel_q      <= 4'd0;
         adr_q      <= 32'd0;
         dat_q      <= 32'd0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'd0;
         err_q      <= 1'b0;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         sel_q      <= sel_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_wb_data_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_wb_data_bridge
//  Description : Self-checking bench for core_wb_data_bridge. Directed cases
//                followed by randomized transactions compared against a
//                transaction-level model of the bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_wb_data_bridge;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] MASK = 32'hF000_0000;
   localparam int          TMO  = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i, gnt_o, rvalid_o, we_i, err_o;
   logic [3:0]  be_i;
   logic [31:0] addr_i, wdata_i, rdata_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i, busy_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic        last_err;
   logic [31:0] last_rd;

   core_wb_data_bridge #(
      .ADDR_BASE (BASE),
      .ADDR_MASK (MASK),
      .TIMEOUT   (8'(TMO))
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .gnt_o     (gnt_o),
      .rvalid_o  (rvalid_o),
      .we_i      (we_i),
      .be_i      (be_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o),
      .err_o     (err_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .wbm_err_i (wbm_err_i),
      .busy_o    (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Idle cycles: no bus activity, no response, previous response retained.
   // A stray ack/err may be driven to show it is ignored outside a cycle.
   task automatic idle(input int n, input logic stray);
      for (int i = 0; i < n; i++) begin
         wbm_ack_i = stray;
         wbm_err_i = 1'b0;
         @(negedge clk_i);
         chk("idle_cyc",    wbm_cyc_o, 0);
         chk("idle_rvalid", rvalid_o,  0);
         chk("idle_busy",   busy_o,    0);
         chk("idle_rdata",  rdata_o,   last_rd);
         chk("idle_err",    err_o,     last_err);
         @(posedge clk_i); #1;
      end
      wbm_ack_i = 1'b0;
   endtask

   // One core transaction. dly: bus cycle index (0 = first cycle with stb)
   // at which the slave answers, -1 = never. Called 1 time unit after a
   // rising edge; returns at the same phase, in the cycle after the response.
   task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input int dly, input bit use_err,
                         input bit both, input logic [31:0] sdat, input bit hold_req);
      bit          in_win;
      int          jend, lat;
      logic        exp_err;
      logic [31:0] exp_rd, exp_adr;
      bit          cyc_exp;

      in_win  = ((addr & MASK) == BASE);
      exp_adr = addr & 32'hFFFF_FFFC;
      if (!in_win) begin
         jend = -1; lat = 1; exp_err = 1'b1; exp_rd = 32'd0;
      end else if (dly >= 0 && dly < TMO) begin
         jend    = dly;
         lat     = dly + 2;
         exp_err = use_err;
         exp_rd  = (use_err || we) ? 32'd0 : sdat;
      end else begin
         jend = TMO; lat = TMO + 2; exp_err = 1'b1; exp_rd = 32'd0;
      end

      req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      @(negedge clk_i);
      chk("gnt_idle",  gnt_o,  1);
      chk("busy_idle", busy_o, 0);

      for (int c = 1; c <= lat; c++) begin
         @(posedge clk_i); #1;
         req_i   = hold_req;
         we_i    = 1'($urandom);
         be_i    = 4'($urandom);
         addr_i  = $urandom;
         wdata_i = $urandom;
         wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
         if (in_win && dly >= 0 && dly < TMO && (c - 1) == dly) begin
            wbm_err_i = use_err;
            wbm_ack_i = !use_err || both;
            wbm_dat_i = sdat;
         end
         cyc_exp = in_win && ((c - 1) <= jend);
         @(negedge clk_i);
         chk("cyc",    wbm_cyc_o, cyc_exp);
         chk("stb",    wbm_stb_o, cyc_exp);
         chk("busy",   busy_o,    1);
         chk("gnt",    gnt_o,     0);
         chk("rvalid", rvalid_o,  (c == lat));
         if (cyc_exp) begin
            chk("wb_we",  wbm_we_o,  we);
            chk("wb_sel", wbm_sel_o, be);
            chk("wb_adr", wbm_adr_o, exp_adr);
            chk("wb_dat", wbm_dat_o, wd);
         end
         if (c == lat) begin
            chk("err",   err_o,   exp_err);
            chk("rdata", rdata_o, exp_rd);
         end
      end
      last_err = exp_err;
      last_rd  = exp_rd;
      @(posedge clk_i); #1;
      req_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          mode, d;

      rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'd0; addr_i = 32'd0;
      wdata_i = 32'd0; wbm_dat_i = 32'd0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      last_err = 1'b0; last_rd = 32'd0;

      // reset values
      repeat (2) @(negedge clk_i);
      chk("rst_cyc",    wbm_cyc_o, 0);
      chk("rst_stb",    wbm_stb_o, 0);
      chk("rst_we",     wbm_we_o,  0);
      chk("rst_sel",    wbm_sel_o, 0);
      chk("rst_adr",    wbm_adr_o, 0);
      chk("rst_dat",    wbm_dat_o, 0);
      chk("rst_rvalid", rvalid_o,  0);
      chk("rst_rdata",  rdata_o,   0);
      chk("rst_err",    err_o,     0);
      chk("rst_busy",   busy_o,    0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // 1: read, answered in second bus cycle -> rvalid at T+3
      do_txn(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      idle(1, 1'b0);
      // 2: write, answered in first bus cycle
      do_txn(1'b1, 4'b0011, 32'h3000_0004, 32'h1234_5678, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
      // 3: out-of-window read, issued immediately after the previous response
      do_txn(1'b0, 4'hF, 32'h2000_0000, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
      // 4: no ack -> timeout; a late ack afterwards is ignored
      do_txn(1'b0, 4'hF, 32'h3000_0100, 32'h0, -1, 1'b0, 1'b0, 32'h0, 1'b0);
      idle(3, 1'b1);
      // 5: ack and err together, req held high through the transaction
      do_txn(1'b0, 4'b0000, 32'h3ABC_DEF3, 32'h0, 2, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1);
      idle(1, 1'b0);

      // 6: async reset while the bus cycle is open
      req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h3000_0020;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("pre_rst_cyc", wbm_cyc_o, 1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_cyc",    wbm_cyc_o, 0);
      chk("arst_stb",    wbm_stb_o, 0);
      chk("arst_rvalid", rvalid_o,  0);
      chk("arst_busy",   busy_o,    0);
      @(negedge clk_i);
      chk("arst_hold_rvalid", rvalid_o, 0);
      rst_ni = 1'b1;
      last_err = 1'b0; last_rd = 32'd0;
      @(posedge clk_i); #1;
      idle(1, 1'b0);
      do_txn(1'b0, 4'hF, 32'h3000_0040, 32'h0, 3, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);

      // randomized transactions
      for (int t = 0; t < 40; t++) begin
         a = $urandom;
         if ($urandom_range(0, 9) < 7) a = BASE | (a & ~MASK);
         else if ((a & MASK) == BASE) a = a ^ 32'h6000_0000;
         mode = $urandom_range(0, 3);
         d    = $urandom_range(0, TMO - 1);
         case (mode)
            0, 1: do_txn(1'($urandom), 4'($urandom), a, $urandom, d, 1'b0, 1'b0, $urandom, 1'($urandom));
            2:    do_txn(1'($urandom), 4'($urandom), a, $urandom, d, 1'b1, 1'($urandom), $urandom, 1'($urandom));
            default: do_txn(1'($urandom), 4'($urandom), a, $urandom, -1, 1'b0, 1'b0, $urandom, 1'($urandom));
         endcase
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
